// File: rtl/enoc_adaptive_route_unit.sv
// Route computation stage for one ENoC router input port.
// Computes a one-hot output-port request [c,n,e,s,w] for the incoming destination.
// Mesh or torus, dimension-ordered or credit-adaptive minimal routing.
// The result sits in a single output register behind a valid/enable handshake.
module enoc_adaptive_route_unit #(
  parameter int X_NODES  = 4,
  parameter int Y_NODES  = 4,
  parameter int X_LOC    = 0,
  parameter int Y_LOC    = 0,
  parameter int TOPOLOGY = 0,
  parameter int ADAPTIVE = 1,
  parameter int CREDIT_W = 3,
  localparam int XW = (X_NODES > 1) ? $clog2(X_NODES) : 1,
  localparam int YW = (Y_NODES > 1) ? $clog2(Y_NODES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [XW-1:0]            i_x_dest,
  input  logic [YW-1:0]            i_y_dest,
  input  logic                     i_val,
  output logic                     o_en,
  input  logic [0:3][CREDIT_W-1:0] i_credit,
  output logic [0:4]               o_output_req,
  output logic                     o_val,
  input  logic                     i_en,
  output logic [15:0]              o_adapt_cnt
);

  localparam logic [0:4] REQ_C = 5'b10000;
  localparam logic [0:4] REQ_N = 5'b01000;
  localparam logic [0:4] REQ_E = 5'b00100;
  localparam logic [0:4] REQ_S = 5'b00010;
  localparam logic [0:4] REQ_W = 5'b00001;

  // Two spare bits leave room for dest + NODES - loc and for doubling a ring distance.
  localparam logic [XW+1:0] X_LOC_W = (XW+2)'(X_LOC);
  localparam logic [XW+1:0] X_N_W   = (XW+2)'(X_NODES);
  localparam logic [YW+1:0] Y_LOC_W = (YW+2)'(Y_LOC);
  localparam logic [YW+1:0] Y_N_W   = (YW+2)'(Y_NODES);

  logic [0:4]  req_q, req_d;
  logic        val_q, val_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rr_q, rr_d;

  logic [XW+1:0] x_dest_w, x_diff;
  logic [YW+1:0] y_dest_w, y_diff;
  logic          x_pos, x_neg, y_pos, y_neg;
  logic          x_prod, y_prod;
  logic [CREDIT_W-1:0] cred_x, cred_y;
  logic [0:4]    x_req, y_req, route;
  logic          pick_y, tie, accept;

  assign o_en   = !val_q || i_en;
  assign accept = i_val && o_en;

  // Productive direction per dimension; on a ring the shorter way wins, half-ring goes positive.
  always_comb begin
    x_dest_w = {2'b00, i_x_dest};
    y_dest_w = {2'b00, i_y_dest};
    x_diff   = '0;
    y_diff   = '0;
    x_pos    = 1'b0;
    x_neg    = 1'b0;
    y_pos    = 1'b0;
    y_neg    = 1'b0;
    if (TOPOLOGY == 1) begin
      x_diff = (x_dest_w >= X_LOC_W) ? (x_dest_w - X_LOC_W) : (x_dest_w + X_N_W - X_LOC_W);
      y_diff = (y_dest_w >= Y_LOC_W) ? (y_dest_w - Y_LOC_W) : (y_dest_w + Y_N_W - Y_LOC_W);
      if (x_diff != '0) begin
        x_pos = ((x_diff << 1) <= X_N_W);
        x_neg = !x_pos;
      end
      if (y_diff != '0) begin
        y_pos = ((y_diff << 1) <= Y_N_W);
        y_neg = !y_pos;
      end
    end else begin
      x_pos = (x_dest_w > X_LOC_W);
      x_neg = (x_dest_w < X_LOC_W);
      y_pos = (y_dest_w > Y_LOC_W);
      y_neg = (y_dest_w < Y_LOC_W);
    end
  end

  // Route choice: DOR unless both dimensions are productive and adaptive mode picks by credits.
  always_comb begin
    x_prod = x_pos || x_neg;
    y_prod = y_pos || y_neg;
    x_req  = x_pos ? REQ_E : REQ_W;
    y_req  = y_pos ? REQ_N : REQ_S;
    cred_x = x_pos ? i_credit[1] : i_credit[3];
    cred_y = y_pos ? i_credit[0] : i_credit[2];
    pick_y = 1'b0;
    tie    = 1'b0;
    route  = REQ_C;
    if (x_prod && y_prod && (ADAPTIVE != 0)) begin
      if (cred_y > cred_x) begin
        pick_y = 1'b1;
      end else if (cred_x == cred_y) begin
        tie    = 1'b1;
        pick_y = rr_q;
      end
      route = pick_y ? y_req : x_req;
    end else if (x_prod) begin
      route = x_req;
    end else if (y_prod) begin
      route = y_req;
    end
  end

  // Output register next state: load on accept, clear on drain, otherwise hold.
  always_comb begin
    req_d = req_q;
    val_d = val_q;
    cnt_d = cnt_q;
    rr_d  = rr_q;
    if (accept) begin
      req_d = route;
      val_d = 1'b1;
      if (tie) begin
        rr_d = !rr_q;
      end
      if (x_prod && pick_y && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (val_q && i_en) begin
      req_d = '0;
      val_d = 1'b0;
    end
  end

  // State registers; reset discards any held request and restores X preference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
      val_q <= 1'b0;
      cnt_q <= '0;
      rr_q  <= 1'b0;
    end else begin
      req_q <= req_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
    end
  end

  assign o_output_req = req_q;
  assign o_val        = val_q;
  assign o_adapt_cnt  = cnt_q;

endmodule
